dfr_mem_arbiter: RTL and testbench

- Shares one single-port, 1-cycle-read RAM (input, reservoir history, weight or DFR output memory) among NUM_REQ requesters.
- Requester 0 is the AXI host memory window. Requesters 1..NUM_REQ-1 are core engines, e.g. the reservoir history writer and the matrix multiplier reader.
- Replaces the static busy-based address/wen muxes in the DFR top. Provides per-cycle arbitration, burst locking, starvation protection and tagged read-data return.

---
 rtl/dfr_mem_arbiter_if.sv | 26 ++
 rtl/dfr_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dfr_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dfr_mem_arbiter_if.sv
// Requester-side bundle of the DFR memory arbiter: packed per-requester request
// fields in, one-hot grant/read-valid and broadcast read data out.
interface dfr_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 3
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            lock;
  logic [NUM_REQ-1:0]            wen;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] din;
  logic [NUM_REQ-1:0]            gnt;
  logic [DATA_WIDTH-1:0]         rdata;
  logic [NUM_REQ-1:0]            rvalid;

  modport master (
    output req, lock, wen, addr, din,
    input  gnt, rdata, rvalid
  );

  modport slave (
    input  req, lock, wen, addr, din,
    output gnt, rdata, rvalid
  );
endinterface

// File: rtl/dfr_mem_arbiter.sv
// Single-port RAM arbiter for the DFR core: host window plus core engines, with
// burst locking, starvation override, round-robin fairness and tagged read return.
module dfr_mem_arbiter #(
  parameter int ADDR_WIDTH    = 14,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REQ       = 3,
  parameter int HOST_PRIORITY = 1,
  parameter int MAX_WAIT      = 15
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  dfr_mem_arbiter_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wen,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int          IW       = $clog2(NUM_REQ);
  localparam int unsigned NREQ     = NUM_REQ;
  localparam logic [7:0]  WAIT_SAT = 8'(MAX_WAIT);

  typedef logic [IW-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(NUM_REQ - 1);

  idx_t                       rr_ptr_q, rr_ptr_d;
  idx_t                       owner_q, owner_d;
  logic                       owner_vld_q, owner_vld_d;
  idx_t                       sel_q, sel_d;
  logic [NUM_REQ-1:0]         rvalid_q, rvalid_d;
  logic [NUM_REQ-1:1][7:0]    wait_q, wait_d;

  logic                       gnt_vld;
  idx_t                       gnt_idx;
  idx_t                       mux_idx;
  logic [NUM_REQ-1:0]         gnt_vec;
  logic [ADDR_WIDTH-1:0]      addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0]      din_a  [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      addr_a[i] = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      din_a[i]  = bus.din[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Priority chain: locked owner, starving core (lowest index), host, round-robin.
  always_comb begin
    int unsigned rr_pos;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_pos  = 0;
    if (owner_vld_q && bus.req[owner_q]) begin
      gnt_vld = 1'b1;
      gnt_idx = owner_q;
    end else begin
      for (int unsigned i = 1; i < NREQ; i++) begin
        if (!gnt_vld && bus.req[idx_t'(i)] && (wait_q[idx_t'(i)] == WAIT_SAT)) begin
          gnt_vld = 1'b1;
          gnt_idx = idx_t'(i);
        end
      end
      if (!gnt_vld && (HOST_PRIORITY != 0) && bus.req[0]) begin
        gnt_vld = 1'b1;
        gnt_idx = '0;
      end
      for (int unsigned k = 0; k < NREQ; k++) begin
        rr_pos = 32'(rr_ptr_q) + k;
        if (rr_pos >= NREQ) rr_pos = rr_pos - NREQ;
        if (!gnt_vld && bus.req[idx_t'(rr_pos)]) begin
          gnt_vld = 1'b1;
          gnt_idx = idx_t'(rr_pos);
        end
      end
    end
    if (!S_AXI_ARESETN) begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
    end
  end

  // When idle the RAM side keeps pointing at the last granted slice.
  always_comb begin
    mux_idx = gnt_vld ? gnt_idx : sel_q;
    gnt_vec = '0;
    if (gnt_vld) gnt_vec[gnt_idx] = 1'b1;
    ram_addr = addr_a[mux_idx];
    ram_din  = din_a[mux_idx];
    ram_wen  = gnt_vld & bus.wen[gnt_idx];
  end

  assign bus.gnt    = gnt_vec;
  assign bus.rdata  = ram_dout;
  assign bus.rvalid = rvalid_q;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    if (gnt_vld) begin
      rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + idx_t'(1);
      sel_d    = gnt_idx;
    end
    // A lock=0 access by the owner is still granted above; ownership ends here.
    if (gnt_vld && bus.lock[gnt_idx]) begin
      owner_vld_d = 1'b1;
      owner_d     = gnt_idx;
    end else if (owner_vld_q && !(bus.req[owner_q] && bus.lock[owner_q])) begin
      owner_vld_d = 1'b0;
    end
    rvalid_d = gnt_vec & ~bus.wen;
    for (int unsigned i = 1; i < NREQ; i++) begin
      if (!bus.req[idx_t'(i)] || gnt_vec[idx_t'(i)]) begin
        wait_d[idx_t'(i)] = '0;
      end else if (wait_q[idx_t'(i)] == WAIT_SAT) begin
        wait_d[idx_t'(i)] = wait_q[idx_t'(i)];
      end else begin
        wait_d[idx_t'(i)] = wait_q[idx_t'(i)] + 8'd1;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rr_ptr_q    <= idx_t'(1);
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      sel_q       <= '0;
      rvalid_q    <= '0;
      wait_q      <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      sel_q       <= sel_d;
      rvalid_q    <= rvalid_d;
      wait_q      <= wait_d;
    end
  end

endmodule

// File: tb/tb_dfr_mem_arbiter.sv
// Directed bench for dfr_mem_arbiter: one host-priority instance (MAX_WAIT=3)
// and one pure round-robin instance, each backed by a 1-cycle-read RAM model.
module tb_dfr_mem_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dfr_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) if_hp ();
  dfr_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) if_rr ();

  logic [AW-1:0] hp_ram_addr, rr_ram_addr;
  logic          hp_ram_wen, rr_ram_wen;
  logic [DW-1:0] hp_ram_din, rr_ram_din, hp_ram_dout, rr_ram_dout;

  dfr_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .HOST_PRIORITY(1), .MAX_WAIT(3)
  ) u_hp (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .bus(if_hp),
    .ram_addr(hp_ram_addr), .ram_wen(hp_ram_wen), .ram_din(hp_ram_din), .ram_dout(hp_ram_dout)
  );

  dfr_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .HOST_PRIORITY(0), .MAX_WAIT(3)
  ) u_rr (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .bus(if_rr),
    .ram_addr(rr_ram_addr), .ram_wen(rr_ram_wen), .ram_din(rr_ram_din), .ram_dout(rr_ram_dout)
  );

  logic [DW-1:0] mem_hp [0:16383];
  logic [DW-1:0] mem_rr [0:16383];

  always @(posedge clk) begin
    if (hp_ram_wen) mem_hp[hp_ram_addr] <= hp_ram_din;
    hp_ram_dout <= mem_hp[hp_ram_addr];
    if (rr_ram_wen) mem_rr[rr_ram_addr] <= rr_ram_din;
    rr_ram_dout <= mem_rr[rr_ram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected grant owners, worked out by hand from the priority rules.
  int rr_idx [6]  = '{1, 2, 0, 1, 2, 0};
  int hp_idx [10] = '{0, 0, 0, 1, 2, 0, 0, 1, 2, 0};

  initial begin
    logic [2:0] prev;
    logic [2:0] exp_g;

    if_hp.req = '0; if_hp.lock = '0; if_hp.wen = '0; if_hp.addr = '0; if_hp.din = '0;
    if_rr.req = '0; if_rr.lock = '0; if_rr.wen = '0; if_rr.addr = '0; if_rr.din = '0;
    mem_hp[14'h0010] = 32'hA5A5_0010;
    for (int i = 0; i < 3; i++) begin
      mem_hp[14'h0100 + 14'(i)] = 32'hB0B0_0000 + 32'(i);
      mem_rr[14'h0200 + 14'(i)] = 32'hC0DE_0000 + 32'(i);
    end

    // Requests presented during reset must not be granted.
    if_hp.req = 3'b111; if_hp.wen = 3'b111; if_hp.lock = 3'b111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", if_hp.gnt, 3'b000);
    check("rst_ram_wen", hp_ram_wen, 1'b0);
    check("rst_rvalid", if_hp.rvalid, 3'b000);
    if_hp.req = '0; if_hp.wen = '0; if_hp.lock = '0;
    rst_n = 1'b1;

    // Host-only read
    @(posedge clk); #1;
    if_hp.addr[0*AW +: AW] = 14'h0010;
    if_hp.req = 3'b001;
    @(negedge clk);
    check("host_gnt", if_hp.gnt, 3'b001);
    check("host_ram_addr", hp_ram_addr, 14'h0010);
    check("host_ram_wen", hp_ram_wen, 1'b0);
    check("host_rvalid_early", if_hp.rvalid, 3'b000);
    @(posedge clk); #1;
    if_hp.req = '0;
    if_hp.addr[1*AW +: AW] = 14'h03AB;
    @(negedge clk);
    check("host_rvalid", if_hp.rvalid, 3'b001);
    check("host_rdata", if_hp.rdata, 32'hA5A5_0010);
    check("idle_gnt", if_hp.gnt, 3'b000);
    check("idle_addr_hold", hp_ram_addr, 14'h0010);
    @(posedge clk); #1;
    @(negedge clk);
    check("host_rvalid_once", if_hp.rvalid, 3'b000);

    // Pure round-robin, all requesting
    for (int i = 0; i < 3; i++) if_rr.addr[i*AW +: AW] = 14'h0200 + 14'(i);
    prev = 3'b000;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if_rr.req = 3'b111;
      @(negedge clk);
      exp_g = 3'b001 << rr_idx[k];
      check("rr_gnt", if_rr.gnt, exp_g);
      check("rr_rvalid", if_rr.rvalid, prev);
      if (k > 0) check("rr_rdata", if_rr.rdata, 32'hC0DE_0000 + 32'(rr_idx[k-1]));
      prev = exp_g;
    end
    @(posedge clk); #1;
    if_rr.req = '0;
    @(negedge clk);
    check("rr_rvalid_last", if_rr.rvalid, 3'b001);
    check("rr_rdata_last", if_rr.rdata, 32'hC0DE_0000);

    // Host priority with starvation override, back-to-back reads
    for (int i = 0; i < 3; i++) if_hp.addr[i*AW +: AW] = 14'h0100 + 14'(i);
    prev = 3'b000;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if_hp.req = 3'b111;
      @(negedge clk);
      exp_g = 3'b001 << hp_idx[k];
      check("cont_gnt", if_hp.gnt, exp_g);
      check("cont_ram_addr", hp_ram_addr, 14'h0100 + 14'(hp_idx[k]));
      check("cont_rvalid", if_hp.rvalid, prev);
      if (k > 0) check("cont_rdata", if_hp.rdata, 32'hB0B0_0000 + 32'(hp_idx[k-1]));
      prev = exp_g;
    end
    @(posedge clk); #1;
    if_hp.req = '0;
    @(negedge clk);
    check("cont_rvalid_last", if_hp.rvalid, 3'b001);

    // Locked burst write by requester 1 against host and a starving requester 2
    if_hp.addr[0*AW +: AW] = 14'd9;
    if_hp.addr[2*AW +: AW] = 14'd5;
    for (int k = 0; k < 13; k++) begin
      @(posedge clk); #1;
      if (k <= 9) begin
        if_hp.addr[1*AW +: AW] = 14'(k);
        if_hp.din[1*DW +: DW]  = 32'(k);
        if_hp.wen  = 3'b010;
        if_hp.lock = (k == 9) ? 3'b000 : 3'b010;
        if_hp.req  = (k == 0) ? 3'b010 : 3'b111;
      end else begin
        if_hp.wen  = 3'b000;
        if_hp.lock = 3'b000;
        if_hp.req  = (k == 10) ? 3'b101 : (k == 11) ? 3'b001 : 3'b000;
      end
      @(negedge clk);
      exp_g = (k <= 9) ? 3'b010 : (k == 10) ? 3'b100 : (k == 11) ? 3'b001 : 3'b000;
      check("lock_gnt", if_hp.gnt, exp_g);
      if (k <= 9) begin
        check("lock_ram_wen", hp_ram_wen, 1'b1);
        check("lock_ram_addr", hp_ram_addr, 14'(k));
        check("lock_ram_din", hp_ram_din, 32'(k));
      end
      if (k == 10) check("lock_rvalid_wr", if_hp.rvalid, 3'b000);
      if (k == 11) begin
        check("lock_rvalid_r2", if_hp.rvalid, 3'b100);
        check("lock_rdata_r2", if_hp.rdata, 32'd5);
      end
      if (k == 12) begin
        check("lock_rvalid_host", if_hp.rvalid, 3'b001);
        check("lock_rdata_host", if_hp.rdata, 32'd9);
      end
    end
    for (int i = 0; i < 10; i++) check("burst_mem", mem_hp[i], 32'(i));

    // Requester 2: write then read the top address
    @(posedge clk); #1;
    if_hp.addr[2*AW +: AW] = 14'h3FFF;
    if_hp.din[2*DW +: DW]  = 32'hDEAD_BEEF;
    if_hp.wen = 3'b100;
    if_hp.req = 3'b100;
    @(negedge clk);
    check("wr_gnt", if_hp.gnt, 3'b100);
    check("wr_ram_wen", hp_ram_wen, 1'b1);
    check("wr_ram_addr", hp_ram_addr, 14'h3FFF);
    check("wr_ram_din", hp_ram_din, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    if_hp.wen = 3'b000;
    @(negedge clk);
    check("rd_gnt", if_hp.gnt, 3'b100);
    check("rd_ram_wen", hp_ram_wen, 1'b0);
    check("wr_no_rvalid", if_hp.rvalid, 3'b000);
    @(posedge clk); #1;
    if_hp.req = 3'b000;
    @(negedge clk);
    check("rd_rvalid", if_hp.rvalid, 3'b100);
    check("rd_rdata", if_hp.rdata, 32'hDEAD_BEEF);

    // Reset with a read in flight; rr_ptr must return to 1
    @(posedge clk); #1;
    if_hp.addr[1*AW +: AW] = 14'h0020;
    if_hp.din[1*DW +: DW]  = 32'h0000_1234;
    if_hp.wen = 3'b010;
    if_hp.req = 3'b010;
    @(negedge clk);
    check("pre_rst_wr_gnt", if_hp.gnt, 3'b010);
    @(posedge clk); #1;
    if_hp.addr[1*AW +: AW] = 14'h0010;
    if_hp.wen = 3'b000;
    @(negedge clk);
    check("pre_rst_rd_gnt", if_hp.gnt, 3'b010);
    rst_n = 1'b0;
    if_hp.req = 3'b111; if_hp.wen = 3'b111; if_hp.lock = 3'b111;
    #1;
    check("in_rst_gnt", if_hp.gnt, 3'b000);
    check("in_rst_ram_wen", hp_ram_wen, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("in_rst_rvalid", if_hp.rvalid, 3'b000);
      check("in_rst_gnt_cyc", if_hp.gnt, 3'b000);
      @(negedge clk);
    end
    if_hp.req = '0; if_hp.wen = '0; if_hp.lock = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    if_hp.req = 3'b110;
    @(negedge clk);
    check("post_rst_gnt", if_hp.gnt, 3'b010);
    check("post_rst_rvalid", if_hp.rvalid, 3'b000);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_gnt2", if_hp.gnt, 3'b100);
    @(posedge clk); #1;
    if_hp.req = '0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
